// File: rtl/smc777_char_fetch.sv
// smc777_char_fetch
// Text-mode pixel generator that sits between the MC6845 CRTC and the video DAC.
// Each 8-pixel cell fetches a character code and an attribute from VRAM, then
// reads the font row from CGROM. The cell is displayed one cell later, with
// reverse, blink and cursor applied. Sync and DE are re-timed to the pixel path.
module smc777_char_fetch #(
    parameter int VRAM_AW      = 12,
    parameter int BLINK_FRAMES = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_ce_pix,
    input  logic               i_de,
    input  logic               i_hsync,
    input  logic               i_vsync,
    input  logic [13:0]        i_ma,
    input  logic [4:0]         i_ra,
    input  logic               i_cursor,
    input  logic [2:0]         i_bg_col,
    output logic [VRAM_AW-1:0] o_vram_addr,
    output logic               o_vram_rd,
    input  logic [7:0]         i_vram_q,
    output logic [10:0]        o_cg_addr,
    output logic               o_cg_rd,
    input  logic [7:0]         i_cg_q,
    output logic [2:0]         o_rgb,
    output logic               o_de,
    output logic               o_hs,
    output logic               o_vs,
    output logic               o_underrun
);

    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CODE_A = 3'd1,
        S_CODE_D = 3'd2,
        S_ATTR_A = 3'd3,
        S_ATTR_D = 3'd4,
        S_FONT_A = 3'd5,
        S_FONT_D = 3'd6
    } state_t;

    state_t             r_state;
    logic [2:0]         r_pix_cnt;
    logic [7:0]         r_de_sr;
    logic [7:0]         r_hs_sr;
    logic [7:0]         r_vs_sr;
    logic [VRAM_AW-2:0] r_ma;
    logic [2:0]         r_ra;
    logic               r_cur;
    logic [7:0]         r_code;
    logic [7:0]         r_buf_font;
    logic [4:0]         r_buf_attr;
    logic               r_buf_cur;
    logic               r_valid;
    logic [7:0]         r_sh_font;
    logic [4:0]         r_sh_attr;
    logic               r_sh_cur;
    logic [FC_W-1:0]    r_fcnt;
    logic               r_blink;

    logic               w_de_rise;
    logic [2:0]         w_pix_nxt;
    logic               w_cell;
    logic               w_ld;
    logic [7:0]         w_font;
    logic [4:0]         w_attr;
    logic               w_cur;
    logic               w_bit_glyph;
    logic               w_bit;
    logic [2:0]         w_pix_rgb;
    logic               w_vs_rise;
    logic               w_unused;

    // r_de_sr[0] is the DE value sampled on the previous pixel enable
    assign w_de_rise = i_de & ~r_de_sr[0];
    assign w_pix_nxt = w_de_rise ? 3'd0 : r_pix_cnt + 3'd1;
    assign w_cell    = i_ce_pix & (w_pix_nxt == 3'd0);

    // A completed fetch always leaves the FSM idle, so the idle term only
    // guards against a buffer being used while a restart is in flight.
    assign w_ld   = r_valid & (r_state == S_IDLE);
    assign w_font = w_cell ? (w_ld ? r_buf_font : 8'h00) : r_sh_font;
    assign w_attr = w_cell ? (w_ld ? r_buf_attr : 5'h00) : r_sh_attr;
    assign w_cur  = w_cell ? (w_ld & r_buf_cur) : r_sh_cur;

    assign w_bit_glyph = w_font[3'd7 - w_pix_nxt] ^ w_attr[3] ^ w_cur;
    assign w_bit       = (w_attr[4] & r_blink) ? w_attr[3] : w_bit_glyph;
    assign w_pix_rgb   = w_bit ? w_attr[2:0] : i_bg_col;

    assign w_vs_rise = i_vsync & ~r_vs_sr[0];

    assign w_unused = ^{i_ma[13:VRAM_AW-1], i_ra[4:3]};

    // Fetch sequencer: one state per clock, restarted by every cell start
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            o_vram_addr <= '0;
            o_vram_rd   <= 1'b0;
            o_cg_addr   <= '0;
            o_cg_rd     <= 1'b0;
            o_underrun  <= 1'b0;
            r_ma        <= '0;
            r_ra        <= '0;
            r_cur       <= 1'b0;
            r_code      <= '0;
            r_buf_font  <= '0;
            r_buf_attr  <= '0;
            r_buf_cur   <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            o_vram_rd <= 1'b0;
            o_cg_rd   <= 1'b0;
            if (w_cell) begin
                r_valid <= 1'b0;
                if (r_state != S_IDLE) begin
                    o_underrun <= 1'b1;
                end
                if (i_de) begin
                    r_ma        <= i_ma[VRAM_AW-2:0];
                    r_ra        <= i_ra[2:0];
                    r_cur       <= i_cursor;
                    o_vram_addr <= {i_ma[VRAM_AW-2:0], 1'b0};
                    o_vram_rd   <= 1'b1;
                    r_state     <= S_CODE_A;
                end else begin
                    r_state <= S_IDLE;
                end
            end else begin
                case (r_state)
                    S_CODE_A: r_state <= S_CODE_D;
                    S_CODE_D: begin
                        r_code      <= i_vram_q;
                        o_vram_addr <= {r_ma, 1'b1};
                        o_vram_rd   <= 1'b1;
                        r_state     <= S_ATTR_A;
                    end
                    S_ATTR_A: r_state <= S_ATTR_D;
                    S_ATTR_D: begin
                        r_buf_attr <= i_vram_q[4:0];
                        o_cg_addr  <= {r_code, r_ra};
                        o_cg_rd    <= 1'b1;
                        r_state    <= S_FONT_A;
                    end
                    S_FONT_A: r_state <= S_FONT_D;
                    S_FONT_D: begin
                        r_buf_font <= i_cg_q;
                        r_buf_cur  <= r_cur;
                        r_valid    <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Pixel counter, cell shifter, pixel output and sync re-timing
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pix_cnt <= '0;
            r_sh_font <= '0;
            r_sh_attr <= '0;
            r_sh_cur  <= 1'b0;
            r_de_sr   <= '0;
            r_hs_sr   <= '0;
            r_vs_sr   <= '0;
            o_rgb     <= '0;
            o_de      <= 1'b0;
            o_hs      <= 1'b0;
            o_vs      <= 1'b0;
        end else if (i_ce_pix) begin
            r_pix_cnt <= w_pix_nxt;
            if (w_cell) begin
                r_sh_font <= w_font;
                r_sh_attr <= w_attr;
                r_sh_cur  <= w_cur;
            end
            o_rgb   <= r_de_sr[7] ? w_pix_rgb : 3'd0;
            o_de    <= r_de_sr[7];
            o_hs    <= r_hs_sr[7];
            o_vs    <= r_vs_sr[7];
            r_de_sr <= {r_de_sr[6:0], i_de};
            r_hs_sr <= {r_hs_sr[6:0], i_hsync};
            r_vs_sr <= {r_vs_sr[6:0], i_vsync};
        end
    end

    // Blink phase: toggles once every BLINK_FRAMES vsync rising edges
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_fcnt  <= '0;
            r_blink <= 1'b0;
        end else if (i_ce_pix && w_vs_rise) begin
            if (r_fcnt == FC_W'(BLINK_FRAMES - 1)) begin
                r_fcnt  <= '0;
                r_blink <= ~r_blink;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_smc777_char_fetch.sv
// Randomised bench for smc777_char_fetch against a cell-level reference model.
module tb_smc777_char_fetch;

    localparam int VRAM_AW = 12;
    localparam int BF      = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               ce_pix = 1'b0;
    logic               de = 1'b0;
    logic               hsync = 1'b0;
    logic               vsync = 1'b0;
    logic [13:0]        ma = '0;
    logic [4:0]         ra = '0;
    logic               cursor = 1'b0;
    logic [2:0]         bg_col = '0;
    logic [VRAM_AW-1:0] vram_addr;
    logic               vram_rd;
    logic [7:0]         vram_q = '0;
    logic [10:0]        cg_addr;
    logic               cg_rd;
    logic [7:0]         cg_q = '0;
    logic [2:0]         rgb;
    logic               de_o;
    logic               hs_o;
    logic               vs_o;
    logic               underrun;

    smc777_char_fetch #(.VRAM_AW(VRAM_AW), .BLINK_FRAMES(BF)) u_dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_ce_pix   (ce_pix),
        .i_de       (de),
        .i_hsync    (hsync),
        .i_vsync    (vsync),
        .i_ma       (ma),
        .i_ra       (ra),
        .i_cursor   (cursor),
        .i_bg_col   (bg_col),
        .o_vram_addr(vram_addr),
        .o_vram_rd  (vram_rd),
        .i_vram_q   (vram_q),
        .o_cg_addr  (cg_addr),
        .o_cg_rd    (cg_rd),
        .i_cg_q     (cg_q),
        .o_rgb      (rgb),
        .o_de       (de_o),
        .o_hs       (hs_o),
        .o_vs       (vs_o),
        .o_underrun (underrun)
    );

    always #5 clk = ~clk;

    logic [7:0] vram [4096];
    logic [7:0] cgrom [2048];

    // Synchronous memories: data valid the clock after the read strobe
    always @(posedge clk) begin
        if (vram_rd) vram_q <= vram[vram_addr];
        if (cg_rd) cg_q <= cgrom[cg_addr];
    end

    int n_chk  = 0;
    int n_pass = 0;
    int t_clk  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
    endtask

    // Reference model state (spec-level view of cells and frames)
    logic       dq_de [$];
    logic       dq_hs [$];
    logic       dq_vs [$];
    int         m_pix;
    logic       m_prev_de;
    logic       m_prev_vs;
    int         m_rises;
    logic       m_under;
    logic       m_have;
    int         cs_clk;
    logic       cs_de;
    logic [13:0] cs_ma;
    logic [4:0] cs_ra;
    logic       cs_cur;
    logic [7:0] d_font;
    logic [7:0] d_attr;
    logic       d_cur;

    task automatic model_reset();
        dq_de.delete(); dq_hs.delete(); dq_vs.delete();
        for (int i = 0; i < 8; i++) begin
            dq_de.push_back(1'b0); dq_hs.push_back(1'b0); dq_vs.push_back(1'b0);
        end
        m_pix = 0; m_prev_de = 0; m_prev_vs = 0; m_rises = 0; m_under = 0;
        m_have = 0; cs_clk = 0; cs_de = 0; cs_ma = '0; cs_ra = '0; cs_cur = 0;
        d_font = '0; d_attr = '0; d_cur = 0;
    endtask

    // One pixel enable: predict outputs from the inputs just applied
    task automatic model_step();
        logic de8, hs8, vs8, bitv, phase;
        logic [7:0] code;
        logic [2:0] exp_rgb;
        int gap;
        dq_de.push_back(de); dq_hs.push_back(hsync); dq_vs.push_back(vsync);
        de8 = dq_de.pop_front(); hs8 = dq_hs.pop_front(); vs8 = dq_vs.pop_front();
        m_pix = (de && !m_prev_de) ? 0 : (m_pix + 1) % 8;
        m_prev_de = de;
        if (m_pix == 0) begin
            gap = t_clk - cs_clk;
            if (m_have && cs_de && gap <= 6) m_under = 1'b1;
            if (m_have && cs_de && gap >= 7) begin
                code   = vram[{cs_ma[10:0], 1'b0}];
                d_attr = vram[{cs_ma[10:0], 1'b1}];
                d_font = cgrom[{code, cs_ra[2:0]}];
                d_cur  = cs_cur;
            end else begin
                d_font = '0; d_attr = '0; d_cur = 1'b0;
            end
            m_have = 1'b1; cs_clk = t_clk; cs_de = de; cs_ma = ma; cs_ra = ra; cs_cur = cursor;
        end
        phase = ((m_rises / BF) % 2) == 1;
        if (vsync && !m_prev_vs) m_rises++;
        m_prev_vs = vsync;
        bitv = d_font[7 - m_pix] ^ d_attr[3] ^ d_cur;
        if (d_attr[4] && phase) bitv = d_attr[3];
        exp_rgb = !de8 ? 3'd0 : (bitv ? d_attr[2:0] : bg_col);
        check_val("rgb", rgb, exp_rgb);
        check_val("de_o", de_o, de8);
        check_val("hs_o", hs_o, hs8);
        check_val("vs_o", vs_o, vs8);
        check_val("underrun", underrun, m_under);
    endtask

    int de_left = 0;
    int hs_left = 0;
    int vs_left = 0;

    task automatic run_clks(input int n, input int per_lo, input int per_hi,
                            input int hi_lo, input int hi_hi, input int lo_lo, input int lo_hi);
        int gap_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (gap_cnt == 0) begin
                ce_pix  = 1'b1;
                gap_cnt = $urandom_range(per_hi, per_lo) - 1;
                if (de_left <= 0) begin
                    de = ~de;
                    de_left = de ? $urandom_range(hi_hi, hi_lo) : $urandom_range(lo_hi, lo_lo);
                end
                de_left--;
                if (hs_left <= 0) begin hsync = ~hsync; hs_left = $urandom_range(12, 1); end
                hs_left--;
                if (vs_left <= 0) begin vsync = ~vsync; vs_left = $urandom_range(30, 2); end
                vs_left--;
                ma     = 14'($urandom);
                ra     = 5'($urandom);
                cursor = ($urandom_range(7, 0) == 0);
                bg_col = 3'($urandom);
            end else begin
                ce_pix = 1'b0;
                gap_cnt--;
            end
            @(posedge clk);
            t_clk++;
            #1;
            if (ce_pix) model_step();
        end
        @(negedge clk);
        ce_pix = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rgb"}, rgb, 3'd0);
        check_val({tag, "_de"}, {hs_o, vs_o, de_o}, 3'd0);
        check_val({tag, "_under"}, underrun, 1'b0);
        check_val({tag, "_strobes"}, {vram_rd, cg_rd}, 2'd0);
        check_val({tag, "_addr"}, {vram_addr, cg_addr}, 23'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        ce_pix = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_reset_outputs(tag);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Start a fetch, wait for the attribute strobe, then reset during ATTR_D
    task automatic reset_mid_fetch();
        logic seen = 1'b0;
        @(negedge clk); ce_pix = 1'b1; de = 1'b0;
        @(negedge clk); ce_pix = 1'b0;
        @(negedge clk); ce_pix = 1'b1; de = 1'b1;
        @(negedge clk); ce_pix = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (vram_rd && vram_addr[0]) seen = 1'b1;
            else @(negedge clk);
        end
        check_val("attr_strobe_seen", seen, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_val("idle_after_rst", {vram_rd, cg_rd, underrun}, 3'd0);
        model_reset();
        de_left = 0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) vram[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) cgrom[i] = 8'($urandom);
        model_reset();
        do_reset("rst_init");
        run_clks(3000, 2, 3, 8, 60, 3, 20);
        reset_mid_fetch();
        run_clks(2000, 2, 3, 8, 60, 3, 20);
        run_clks(1500, 1, 1, 1, 4, 1, 3);
        do_reset("rst_again");
        run_clks(1500, 1, 2, 8, 40, 1, 10);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
